// File: rtl/multi_cycle_control_if.sv
// Control bus between the multi-cycle MIPS datapath and its main control FSM.
// The datapath side (master) supplies the start request, the current opcode and
// the memory-ready handshake; the controller side (slave) returns every enable
// and mux select plus the debug state code.
interface multi_cycle_control_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2
);
  logic               Start_i;
  logic [OP_W-1:0]    Op_i;
  logic               MemReady_i;
  logic               PCWrite_o;
  logic               PCWriteCond_o;
  logic               IorD_o;
  logic               MemRead_o;
  logic               MemWrite_o;
  logic               IRWrite_o;
  logic               MemtoReg_o;
  logic [1:0]         PCSrc_o;
  logic [ALUOP_W-1:0] ALUOp_o;
  logic               ALUSrcA_o;
  logic [1:0]         ALUSrcB_o;
  logic               RegWrite_o;
  logic               RegDst_o;
  logic               Illegal_o;
  logic [3:0]         State_o;

  modport master (
    output Start_i, Op_i, MemReady_i,
    input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o,
           IRWrite_o, MemtoReg_o, PCSrc_o, ALUOp_o, ALUSrcA_o, ALUSrcB_o,
           RegWrite_o, RegDst_o, Illegal_o, State_o
  );

  modport slave (
    input  Start_i, Op_i, MemReady_i,
    output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o,
           IRWrite_o, MemtoReg_o, PCSrc_o, ALUOp_o, ALUSrcA_o, ALUSrcB_o,
           RegWrite_o, RegDst_o, Illegal_o, State_o
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath. Each instruction walks
// FETCH -> DECODE -> (execute / memory / write-back) -> FETCH, sharing one ALU
// and one memory port. Memory states can stall on the ready handshake, and an
// unsupported opcode returns straight to FETCH with a one-cycle Illegal_o pulse.
module multi_cycle_control #(
  parameter int                   OP_W        = 6,
  parameter int                   ALUOP_W     = 2,
  parameter logic [ALUOP_W-1:0]   ALUOP_RTYPE = 2'b11,
  parameter logic [ALUOP_W-1:0]   ALUOP_ADD   = 2'b00,
  parameter logic [ALUOP_W-1:0]   ALUOP_SUB   = 2'b01,
  parameter bit                   MEM_WAIT_EN = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  multi_cycle_control_if.slave bus
);

  // State codes are visible on State_o, so their values are fixed.
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_MEM_WRITE = 4'd6;
  localparam logic [3:0] S_EXEC_R    = 4'd7;
  localparam logic [3:0] S_WB_R      = 4'd8;
  localparam logic [3:0] S_EXEC_I    = 4'd9;
  localparam logic [3:0] S_WB_I      = 4'd10;
  localparam logic [3:0] S_BRANCH    = 4'd11;
  localparam logic [3:0] S_JUMP      = 4'd12;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  logic [3:0]      state;
  logic [3:0]      state_nxt;
  logic [OP_W-1:0] op_q;
  logic            illegal_q;
  logic            op_illegal;
  logic            rdy;

  logic               pc_write;
  logic               pc_write_cond;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic [1:0]         pc_src;
  logic [ALUOP_W-1:0] alu_op;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic               reg_write;
  logic               reg_dst;

  // With waiting disabled the memory is assumed to answer in a single cycle.
  assign rdy = bus.MemReady_i | ~MEM_WAIT_EN;

  // Flag any opcode the datapath cannot execute; only meaningful in DECODE.
  always_comb begin
    op_illegal = 1'b1;
    case (bus.Op_i)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: op_illegal = 1'b0;
      default:                                       op_illegal = 1'b1;
    endcase
  end

  // Next-state selection; memory states hold until the access is ready.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (bus.Start_i) state_nxt = S_FETCH;
      S_FETCH:     if (rdy) state_nxt = S_DECODE;
      S_DECODE: begin
        case (bus.Op_i)
          OP_RTYPE:     state_nxt = S_EXEC_R;
          OP_ADDI:      state_nxt = S_EXEC_I;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_FETCH;
        endcase
      end
      // Use the opcode captured in DECODE; the live opcode may have moved on.
      S_MEM_ADDR:  state_nxt = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (rdy) state_nxt = S_MEM_WB;
      S_MEM_WB:    state_nxt = S_FETCH;
      S_MEM_WRITE: if (rdy) state_nxt = S_FETCH;
      S_EXEC_R:    state_nxt = S_WB_R;
      S_WB_R:      state_nxt = S_FETCH;
      S_EXEC_I:    state_nxt = S_WB_I;
      S_WB_I:      state_nxt = S_FETCH;
      S_BRANCH:    state_nxt = S_FETCH;
      S_JUMP:      state_nxt = S_FETCH;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // State register and illegal-opcode pulse; reset abandons any access in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      illegal_q <= (state == S_DECODE) && op_illegal;
    end
  end

  // Capture the opcode in DECODE so MEM_ADDR can tell lw from sw later.
  always_ff @(posedge clk_i) begin
    if (state == S_DECODE) op_q <= bus.Op_i;
  end

  // Moore decode of the control word; only FETCH write enables see rdy.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    pc_src        = 2'b00;
    alu_op        = '0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_ADD;
        ir_write  = rdy;
        pc_write  = rdy;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_RTYPE;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_WB_I: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: begin
      end
    endcase
  end

  assign bus.PCWrite_o     = pc_write;
  assign bus.PCWriteCond_o = pc_write_cond;
  assign bus.IorD_o        = iord;
  assign bus.MemRead_o     = mem_read;
  assign bus.MemWrite_o    = mem_write;
  assign bus.IRWrite_o     = ir_write;
  assign bus.MemtoReg_o    = mem_to_reg;
  assign bus.PCSrc_o       = pc_src;
  assign bus.ALUOp_o       = alu_op;
  assign bus.ALUSrcA_o     = alu_src_a;
  assign bus.ALUSrcB_o     = alu_src_b;
  assign bus.RegWrite_o    = reg_write;
  assign bus.RegDst_o      = reg_dst;
  assign bus.Illegal_o     = illegal_q;
  assign bus.State_o       = state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: one instance waits on memory ready,
// a second has waiting disabled with ready tied low.
module tb_multi_cycle_control;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   fails  = 0;
  int   ir_cnt = 0;
  int   pc_cnt = 0;

  multi_cycle_control_if #(.OP_W(6), .ALUOP_W(2)) b0 ();
  multi_cycle_control_if #(.OP_W(6), .ALUOP_W(2)) b1 ();

  multi_cycle_control #(.MEM_WAIT_EN(1'b1)) u0 (.clk_i(clk), .rst_i(rst), .bus(b0));
  multi_cycle_control #(.MEM_WAIT_EN(1'b0)) u1 (.clk_i(clk), .rst_i(rst), .bus(b1));

  always #5 clk = ~clk;

  // Control word order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
  // MemtoReg PCSrc[2] ALUOp[2] ALUSrcA ALUSrcB[2] RegWrite RegDst Illegal State[4]
  logic [20:0] obs0, obs1;
  assign obs0 = {b0.PCWrite_o, b0.PCWriteCond_o, b0.IorD_o, b0.MemRead_o,
                 b0.MemWrite_o, b0.IRWrite_o, b0.MemtoReg_o, b0.PCSrc_o,
                 b0.ALUOp_o, b0.ALUSrcA_o, b0.ALUSrcB_o, b0.RegWrite_o,
                 b0.RegDst_o, b0.Illegal_o, b0.State_o};
  assign obs1 = {b1.PCWrite_o, b1.PCWriteCond_o, b1.IorD_o, b1.MemRead_o,
                 b1.MemWrite_o, b1.IRWrite_o, b1.MemtoReg_o, b1.PCSrc_o,
                 b1.ALUOp_o, b1.ALUSrcA_o, b1.ALUSrcB_o, b1.RegWrite_o,
                 b1.RegDst_o, b1.Illegal_o, b1.State_o};

  // Expected control word for a state, written from the per-state output table.
  function automatic logic [20:0] exp_word(input logic [3:0] st, input logic rdy, input logic ill);
    logic pcw, pcc, iod, mr, mw, irw, m2r, asa, rw, rd;
    logic [1:0] psrc, aop, asb;
    {pcw, pcc, iod, mr, mw, irw, m2r, asa, rw, rd} = '0;
    psrc = 2'b00; aop = 2'b00; asb = 2'b00;
    case (st)
      4'd1:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
      4'd2:  asb = 2'b11;
      4'd3:  begin asa = 1'b1; asb = 2'b10; end
      4'd4:  begin mr = 1'b1; iod = 1'b1; end
      4'd5:  begin rw = 1'b1; m2r = 1'b1; end
      4'd6:  begin mw = 1'b1; iod = 1'b1; end
      4'd7:  begin asa = 1'b1; aop = 2'b11; end
      4'd8:  begin rw = 1'b1; rd = 1'b1; end
      4'd9:  begin asa = 1'b1; asb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin asa = 1'b1; aop = 2'b01; pcc = 1'b1; psrc = 2'b01; end
      4'd12: begin pcw = 1'b1; psrc = 2'b10; end
      default: ;
    endcase
    return {pcw, pcc, iod, mr, mw, irw, m2r, psrc, aop, asa, asb, rw, rd, ill, st};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
    end
  endtask

  // Called at posedge+1: apply ready, settle, check the word, advance one clock.
  task automatic cyc(input int dut, input logic [3:0] st, input logic mr, input logic ill);
    if (dut == 0) b0.MemReady_i = mr;
    #1;
    if (dut == 0) begin
      chk($sformatf("u0_state%0d", st), {11'd0, obs0}, {11'd0, exp_word(st, mr, ill)});
      ir_cnt += int'(b0.IRWrite_o);
      pc_cnt += int'(b0.PCWrite_o);
    end else begin
      chk($sformatf("u1_state%0d", st), {11'd0, obs1}, {11'd0, exp_word(st, 1'b1, ill)});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    b0.Start_i = 1'b0; b0.Op_i = 6'b000000; b0.MemReady_i = 1'b1;
    b1.Start_i = 1'b0; b1.Op_i = 6'b000000; b1.MemReady_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Idle with Start low, then a start pulse
    for (int i = 0; i < 5; i++) cyc(0, 4'd0, 1'b1, 1'b0);
    b0.Start_i = 1'b1;
    cyc(0, 4'd0, 1'b1, 1'b0);
    b0.Start_i = 1'b0;

    // R-type
    b0.Op_i = 6'b000000;
    cyc(0, 4'd1, 1'b1, 1'b0);
    cyc(0, 4'd2, 1'b1, 1'b0);
    cyc(0, 4'd7, 1'b1, 1'b0);
    cyc(0, 4'd8, 1'b1, 1'b0);

    // addi
    b0.Op_i = 6'b001000;
    cyc(0, 4'd1, 1'b1, 1'b0);
    cyc(0, 4'd2, 1'b1, 1'b0);
    cyc(0, 4'd9, 1'b1, 1'b0);
    cyc(0, 4'd10, 1'b1, 1'b0);

    // lw with 2 fetch stalls and 3 read stalls; opcode changes after DECODE
    ir_cnt = 0; pc_cnt = 0;
    b0.Op_i = 6'b100011;
    cyc(0, 4'd1, 1'b0, 1'b0);
    cyc(0, 4'd1, 1'b0, 1'b0);
    cyc(0, 4'd1, 1'b1, 1'b0);
    cyc(0, 4'd2, 1'b1, 1'b0);
    b0.Op_i = 6'b101011;
    cyc(0, 4'd3, 1'b1, 1'b0);
    cyc(0, 4'd4, 1'b0, 1'b0);
    cyc(0, 4'd4, 1'b0, 1'b0);
    cyc(0, 4'd4, 1'b0, 1'b0);
    cyc(0, 4'd4, 1'b1, 1'b0);
    cyc(0, 4'd5, 1'b1, 1'b0);
    chk("lw_irwrite_pulses", ir_cnt, 32'd1);
    chk("lw_pcwrite_pulses", pc_cnt, 32'd1);

    // beq then j, with Start held high to show it is ignored
    b0.Start_i = 1'b1;
    b0.Op_i = 6'b000100;
    cyc(0, 4'd1, 1'b1, 1'b0);
    cyc(0, 4'd2, 1'b1, 1'b0);
    cyc(0, 4'd11, 1'b1, 1'b0);
    b0.Op_i = 6'b000010;
    cyc(0, 4'd1, 1'b1, 1'b0);
    cyc(0, 4'd2, 1'b1, 1'b0);
    cyc(0, 4'd12, 1'b1, 1'b0);
    b0.Start_i = 1'b0;

    // Illegal opcode: single pulse even while the following fetch stalls
    b0.Op_i = 6'b111111;
    cyc(0, 4'd1, 1'b1, 1'b0);
    cyc(0, 4'd2, 1'b1, 1'b0);
    cyc(0, 4'd1, 1'b0, 1'b1);
    cyc(0, 4'd1, 1'b0, 1'b0);

    // sw stalled in MEM_WRITE, then reset mid-access
    b0.Op_i = 6'b101011;
    cyc(0, 4'd1, 1'b1, 1'b0);
    cyc(0, 4'd2, 1'b1, 1'b0);
    cyc(0, 4'd3, 1'b1, 1'b0);
    cyc(0, 4'd6, 1'b0, 1'b0);
    cyc(0, 4'd6, 1'b0, 1'b0);
    rst = 1'b0;
    b0.MemReady_i = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(0, 4'd0, 1'b0, 1'b0);
    cyc(0, 4'd0, 1'b0, 1'b0);

    // No-wait instance: lw completes in 5 cycles with ready tied low
    b1.Start_i = 1'b1;
    cyc(1, 4'd0, 1'b0, 1'b0);
    b1.Start_i = 1'b0;
    b1.Op_i = 6'b100011;
    cyc(1, 4'd1, 1'b0, 1'b0);
    cyc(1, 4'd2, 1'b0, 1'b0);
    cyc(1, 4'd3, 1'b0, 1'b0);
    cyc(1, 4'd4, 1'b0, 1'b0);
    cyc(1, 4'd5, 1'b0, 1'b0);
    b1.Op_i = 6'b000000;
    cyc(1, 4'd1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
